// File: rtl/am_pkg.sv
// Shared types and constants for the associative-memory class store.
package am_pkg;

    localparam int CLASS_STRIDE = 256;
    localparam int CLASS_IDX_W  = 5;
    localparam int MAX_CLASSES  = 32;

    typedef enum logic {
        AM_IDLE,
        AM_CLEAR
    } am_state_e;

    typedef logic [CLASS_IDX_W-1:0] class_idx_t;

endpackage

// File: rtl/am_addr_decode.sv
// Maps an AM read address onto a class row index relative to the
// class-0 base address, flagging misaligned or out-of-range addresses.
module am_addr_decode
    import am_pkg::*;
#(
    parameter int AM_ADDR_WIDTH = 13,
    parameter int NUM_CLASSES   = 26
) (
    input  logic [AM_ADDR_WIDTH-1:0] am_addr_i,
    input  logic [AM_ADDR_WIDTH-1:0] am_addr_base_i,
    output class_idx_t               idx_o,
    output logic                     in_range_o
);

    localparam int HI_W = AM_ADDR_WIDTH - 8;

    logic [AM_ADDR_WIDTH-1:0] off;
    logic [HI_W-1:0]          hi;

    // Offset wraps modulo 2^AM_ADDR_WIDTH so a base near the top still works
    assign off = am_addr_i - am_addr_base_i;
    assign hi  = off[AM_ADDR_WIDTH-1:8];

    assign idx_o      = hi[CLASS_IDX_W-1:0];
    assign in_range_o = (off[7:0] == 8'd0)
                     && ({1'b0, hi} < (HI_W+1)'(NUM_CLASSES));

endmodule

// File: rtl/am_class_store.sv
// Class hypervector store: registered AM reads, training write port, bulk clear.
// Define AM_BUNDLE_OR_EN to let wr_bundle OR a write into the existing row.
module am_class_store
    import am_pkg::*;
#(
    parameter int HV_LENGTH     = 2048,
    parameter int AM_ADDR_WIDTH = 13,
    parameter int NUM_CLASSES   = 26
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     am_ren,
    input  logic [AM_ADDR_WIDTH-1:0] am_addr,
    input  logic [AM_ADDR_WIDTH-1:0] am_addr_base,
    output logic [HV_LENGTH-1:0]     am_rdata,
    output logic                     am_rerr,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [CLASS_IDX_W-1:0]   wr_class,
    input  logic [HV_LENGTH-1:0]     wr_hv,
    input  logic                     wr_bundle,
    input  logic                     clear_i,
    output logic                     busy_o,
    output logic [MAX_CLASSES-1:0]   class_valid_o
);

    localparam class_idx_t LAST_IDX = CLASS_IDX_W'(NUM_CLASSES - 1);

    am_state_e  state_q, state_d;
    class_idx_t cnt_q, cnt_d;

    logic [HV_LENGTH-1:0]   rows_q [NUM_CLASSES];
    logic [MAX_CLASSES-1:0] valid_q;
    logic [HV_LENGTH-1:0]   rdata_q;
    logic                   rerr_q;

    class_idx_t           rd_idx;
    logic                 rd_ok;
    logic [HV_LENGTH-1:0] rd_row;
    logic                 cls_ok;
    logic                 wr_en;
    logic                 clr_en;
    logic [HV_LENGTH-1:0] wr_data;

    am_addr_decode #(
        .AM_ADDR_WIDTH(AM_ADDR_WIDTH),
        .NUM_CLASSES  (NUM_CLASSES)
    ) u_dec (
        .am_addr_i     (am_addr),
        .am_addr_base_i(am_addr_base),
        .idx_o         (rd_idx),
        .in_range_o    (rd_ok)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ready = 1'b0;
        busy_o   = 1'b0;
        clr_en   = 1'b0;
        unique case (state_q)
            AM_IDLE: begin
                // A pending clear wins over a same-cycle write
                wr_ready = !am_ren && !clear_i && !rst_i;
                if (clear_i) begin
                    state_d = AM_CLEAR;
                    cnt_d   = '0;
                end
            end
            AM_CLEAR: begin
                busy_o = 1'b1;
                clr_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = AM_IDLE;
                end
            end
            default: state_d = AM_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= AM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cls_ok = ({1'b0, wr_class} < (CLASS_IDX_W+1)'(NUM_CLASSES));
    assign wr_en  = wr_valid && wr_ready && cls_ok;

`ifdef AM_BUNDLE_OR_EN
    assign wr_data = wr_bundle ? (rows_q[wr_class] | wr_hv) : wr_hv;
`else
    logic unused_bundle;
    assign unused_bundle = wr_bundle;
    assign wr_data       = wr_hv;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                rows_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (clr_en) begin
            rows_q[cnt_q]  <= '0;
            valid_q[cnt_q] <= 1'b0;
        end else if (wr_en) begin
            rows_q[wr_class]  <= wr_data;
            valid_q[wr_class] <= 1'b1;
        end
    end

    assign rd_row = rd_ok ? rows_q[rd_idx] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else if (am_ren) begin
            rdata_q <= rd_row;
            rerr_q  <= !rd_ok;
        end
    end

    assign am_rdata      = rdata_q;
    assign am_rerr       = rerr_q;
    assign class_valid_o = valid_q;

endmodule

// File: tb/tb_am_class_store.sv
// Scoreboarded bench for am_class_store: reads, writes, bundling, clear, reset.
module tb_am_class_store;

    localparam int HV = 2048;
    localparam int AW = 13;
    localparam int NC = 26;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          am_ren;
    logic [AW-1:0] am_addr;
    logic [AW-1:0] am_addr_base;
    logic [HV-1:0] am_rdata;
    logic          am_rerr;
    logic          wr_valid;
    logic          wr_ready;
    logic [4:0]    wr_class;
    logic [HV-1:0] wr_hv;
    logic          wr_bundle;
    logic          clear_i;
    logic          busy_o;
    logic [31:0]   class_valid_o;

    am_class_store #(
        .HV_LENGTH(HV), .AM_ADDR_WIDTH(AW), .NUM_CLASSES(NC)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .am_ren(am_ren), .am_addr(am_addr),
        .am_addr_base(am_addr_base),
        .am_rdata(am_rdata), .am_rerr(am_rerr),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_class(wr_class), .wr_hv(wr_hv),
        .wr_bundle(wr_bundle), .clear_i(clear_i),
        .busy_o(busy_o), .class_valid_o(class_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [HV-1:0] data;
        logic          err;
    } rd_exp_t;

    rd_exp_t       sb[$];
    logic [HV-1:0] model [NC];
    logic [31:0]   mvalid;
    int            checks = 0;
    int            errors = 0;
    logic          rd_fire = 1'b0;

    always @(posedge clk) rd_fire <= am_ren && !rst_i;

    always @(negedge clk) begin
        if (rd_fire) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got err=%0b", am_rerr);
            end else begin
                rd_exp_t e;
                e = sb.pop_front();
                if (am_rdata !== e.data || am_rerr !== e.err) begin
                    errors++;
                    $display("FAIL rd_data got %h/%0b want %h/%0b",
                             am_rdata[31:0], am_rerr, e.data[31:0], e.err);
                end
            end
        end
    end

    function automatic rd_exp_t exp_for(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        int            idx;
        rd_exp_t       e;
        off = a - am_addr_base;
        idx = int'(off >> 8);
        if (off[7:0] == 8'd0 && idx < NC) begin
            e.data = model[idx];
            e.err  = 1'b0;
        end else begin
            e.data = '0;
            e.err  = 1'b1;
        end
        return e;
    endfunction

    // drive one read at the current negedge; the monitor checks it
    task automatic rd(input logic [AW-1:0] a);
        am_ren  = 1'b1;
        am_addr = a;
        sb.push_back(exp_for(a));
        @(negedge clk);
        am_ren = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) model[i] = '0;
        mvalid = '0;
    endtask

    task automatic wr(input int c, input logic [HV-1:0] hv,
                      input logic b);
        bit done;
        done      = 0;
        wr_valid  = 1'b1;
        wr_class  = 5'(c);
        wr_hv     = hv;
        wr_bundle = b;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (wr_ready) begin
                done = 1;
                if (c < NC) begin
`ifdef AM_BUNDLE_OR_EN
                    model[c] = b ? (model[c] | hv) : hv;
`else
                    model[c] = hv;
`endif
                    mvalid[c] = 1'b1;
                end
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wr_timeout class %0d got ready=0 want 1", c);
        end
    endtask

    function automatic logic [HV-1:0] rand_hv();
        logic [HV-1:0] v;
        for (int i = 0; i < HV/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_valid(input string nm);
        checks++;
        if (class_valid_o !== mvalid) begin
            errors++;
            $display("FAIL %s class_valid got %h want %h",
                     nm, class_valid_o, mvalid);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; am_ren = 0; am_addr = 0; am_addr_base = 13'h100;
        wr_valid = 0; wr_class = 0; wr_hv = '0; wr_bundle = 0;
        clear_i = 0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (am_rdata !== '0 || am_rerr !== 0 || wr_ready !== 0
            || busy_o !== 0 || class_valid_o !== 0) begin
            errors++;
            $display("FAIL reset_state got rerr=%0b rdy=%0b busy=%0b cv=%h want 0",
                     am_rerr, wr_ready, busy_o, class_valid_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        rd(13'h100);
        @(negedge clk);
    endtask

    task automatic test_write_read();
        wr(3, {256{8'hA5}}, 1'b0);
        rd(am_addr_base + 13'h300);
        @(negedge clk);
        chk_valid("cv_class3");
        checks++;
        if (model[3] !== {256{8'hA5}}) begin
            errors++;
            $display("FAIL model_c3 got %h want a5a5a5a5", model[3][31:0]);
        end
    endtask

    task automatic test_errors();
        rd(am_addr_base + 13'h310);
        rd(am_addr_base + 13'(NC*256));
        rd(am_addr_base + 13'h300);
        rd(am_addr_base - 13'h100);
        // base near the top of the space: offset wraps
        am_addr_base = 13'h1F00;
        rd(13'h0200);
        rd(13'h1F01);
        am_addr_base = 13'h100;
        @(negedge clk);
    endtask

    task automatic test_read_priority();
        logic [HV-1:0] hv;
        hv        = rand_hv();
        wr_valid  = 1'b1;
        wr_class  = 5'd5;
        wr_hv     = hv;
        wr_bundle = 1'b0;
        for (int k = 0; k < 4; k++) begin
            am_ren  = 1'b1;
            am_addr = am_addr_base + 13'h500;
            sb.push_back(exp_for(am_addr));
            #1;
            checks++;
            if (wr_ready !== 1'b0) begin
                errors++;
                $display("FAIL rd_prio cyc %0d got ready=%0b want 0", k, wr_ready);
            end
            @(negedge clk);
        end
        am_ren = 1'b0;
        wr(5, hv, 1'b0);
        rd(am_addr_base + 13'h500);
        @(negedge clk);
        chk_valid("cv_class5");
        // out-of-range class: handshake completes, nothing stored
        wr(30, rand_hv(), 1'b0);
        @(negedge clk);
        chk_valid("cv_class30");
    endtask

    task automatic test_bundle();
        wr(1, {256{8'h0F}}, 1'b0);
        wr(1, {256{8'hF0}}, 1'b1);
        rd(am_addr_base + 13'h100);
        @(negedge clk);
        checks++;
`ifdef AM_BUNDLE_OR_EN
        if (model[1] !== {256{8'hFF}}) begin
`else
        if (model[1] !== {256{8'hF0}}) begin
`endif
            errors++;
            $display("FAIL bundle_model got %h", model[1][31:0]);
        end
    endtask

    task automatic test_clear();
        int busy_n;
        for (int c = 0; c < NC; c++) wr(c, rand_hv(), 1'b0);
        chk_valid("cv_all");
        rd(am_addr_base + 13'(25*256));
        // clear with a competing write: the write must be refused
        clear_i  = 1'b1;
        wr_valid = 1'b1; wr_class = 5'd7; wr_hv = '1;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_prio got ready=%0b want 0", wr_ready);
        end
        @(negedge clk);
        clear_i = 1'b0; wr_valid = 1'b0;
        // row 25 still old at the first CLEAR edge
        rd(am_addr_base + 13'(25*256));
        model[0] = '0;
        rd(am_addr_base);
        busy_n = 2;
        for (int k = 0; k < 60 && busy_o; k++) begin
            busy_n++;
            @(negedge clk);
        end
        checks++;
        if (busy_n != NC) begin
            errors++;
            $display("FAIL clr_busy got %0d cycles want %0d", busy_n, NC);
        end
        model_reset();
        chk_valid("cv_cleared");
        for (int c = 0; c < NC; c += 5) rd(am_addr_base + 13'(c*256));
        rd(am_addr_base + 13'(25*256));
        @(negedge clk);
    endtask

    task automatic test_reset_mid_clear();
        wr(9, rand_hv(), 1'b0);
        rd(am_addr_base + 13'h900);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 0 || class_valid_o !== 0 || am_rdata !== '0
            || am_rerr !== 0 || wr_ready !== 0) begin
            errors++;
            $display("FAIL rst_mid_clear got busy=%0b cv=%h rdy=%0b want 0",
                     busy_o, class_valid_o, wr_ready);
        end
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
        @(negedge clk);
        rd(am_addr_base + 13'h900);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_busy got %0b want 0", busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_read_priority();
        test_bundle();
        test_clear();
        test_reset_mid_clear();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
